uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between two byte producers, for example a command-response path and a debug/log path.
- Buffers each producer in a small FIFO and picks the next byte by round-robin.
- Drives the transmitter's Tx_DATA/Tx_WR/Tx_EN/baud_select and runs the Tx_WR -> Tx_BUSY handshake for every byte.
- Sits directly between the producers and uart_transmitter. It is the only block that drives the transmitter inputs.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of 2, at least 2.
- ACK_TIMEOUT, 64, clk cycles allowed for tx_busy to rise after tx_wr asserts (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- en  in  1  arbiter enable; maps onto transmitter Tx_EN.
- baud_cfg  in  3  requested baud code, same encoding as the transmitter's baud_select.
- req0_valid  in  1  requester 0 byte valid.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 FIFO not full.
- req1_valid  in  1  requester 1 byte valid.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 FIFO not full.
- tx_data  out  8  to transmitter Tx_DATA.
- tx_wr  out  1  to transmitter Tx_WR.
- tx_en  out  1  to transmitter Tx_EN.
- baud_select  out  3  to transmitter baud_select.
- tx_busy  in  1  from transmitter Tx_BUSY.
- grant_id  out  1  requester that owns the current or last byte.
- err  out  1  sticky ack-timeout flag (optional feature only; otherwise tied to 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: tx_data=0, tx_wr=0, tx_en=0, baud_select=3'b000, grant_id=0, err=0.
  - FIFOs emptied; req*_ready=0 while reset is asserted, then 1 on the first clk after release.
  - state=IDLE; round-robin pointer set so requester 0 wins the first tie.
- FIFO push: on reqN_valid && reqN_ready.
  - reqN_ready = !full, registered from the count.
  - Push while full is impossible; valid without ready is ignored.
  - Push and pop in the same cycle on the same FIFO: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- tx_en is registered from en.
- State IDLE:
  - tx_wr=0.
  - baud_select loads baud_cfg every cycle in IDLE only, so baud changes never affect a byte in flight.
  - If en && any FIFO non-empty:
    - Grant the non-empty requester other than the last grant; if only one is non-empty, grant it.
    - Pop its head into tx_data, set grant_id, go to WRITE.
  - Entering WRITE takes one cycle, so there is at least one IDLE cycle between bytes.
- State WRITE:
  - tx_wr=1, tx_data held stable.
  - When tx_busy is sampled 1: tx_wr=0 next cycle, go to BUSY.
- State BUSY:
  - tx_wr=0.
  - Wait until tx_busy is sampled 0, then update the round-robin pointer to grant_id and go to IDLE.
- en dropping mid-byte:
  - tx_en falls, but the current WRITE/BUSY sequence still runs to completion.
  - No new grant while en=0.
  - FIFOs keep accepting data.
- tx_busy already high in IDLE (foreign or stale frame): no grant until it is 0.
- Reset mid-byte: immediate return to reset values; the FIFO contents and the popped byte are discarded.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WRITE.
  - If tx_busy has not risen after ACK_TIMEOUT cycles: tx_wr drops, the byte is dropped, err sets (sticky until reset), and the state returns to IDLE with the pointer advanced.
- Undefined:
  - WRITE waits indefinitely; err is tied to 0 and no counter logic is built.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE=2'd0, WRITE=2'd1, BUSY=2'd2.
  - Baud code constants, shared with the transmitter and receiver.
  - Byte width constant, 8.
- One sub-module: uart_byte_fifo (DEPTH-parameterised synchronous FIFO with push/pop/full/empty/count), instantiated twice.

Test Plan:
- Single byte, single requester:
  - Stimulus: reset low for 100 ns; en=1, baud_cfg=3'b011; req0 pushes 8'h78.
  - Response: tx_wr rises 2 cycles after the push and falls the cycle after tx_busy rises; TxD serialises 0x78; grant_id=0.
- Contention:
  - Stimulus: both FIFOs preloaded, req0 with A1,A2 and req1 with B1,B2.
  - Response: transmit order A1,B1,A2,B2.
- Full FIFO:
  - Stimulus: push 5 bytes to req0 with DEPTH=4 while en=0.
  - Response: req0_ready goes 0 after the 4th push, the 5th is not accepted, and only 4 bytes are sent after en=1.
- Baud change mid-frame:
  - Stimulus: change baud_cfg from 3'b011 to 3'b111 while in BUSY.
  - Response: baud_select stays 3'b011 until the next IDLE.
- Reset mid-frame:
  - Stimulus: reset=0 during BUSY.
  - Response: tx_wr=0, tx_en=0 and FIFOs empty immediately; after release, nothing is sent until a new push.
- Timeout (UART_ARB_TIMEOUT_EN):
  - Stimulus: tx_busy held at 0.
  - Response: tx_wr high for exactly 64 cycles, then err=1 and the next requester is granted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, baud codes, byte width.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    // Baud codes, common to transmitter, receiver and arbiter.
    localparam logic [2:0] BAUD_1200   = 3'b000;
    localparam logic [2:0] BAUD_2400   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO with a registered ready (not-full) flag.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q;

    // Occupancy after this cycle's push/pop; simultaneous push+pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and ready; ready stays low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign ready = ready_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers.
// Optional ack timeout in WRITE is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] baud_cfg,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       tx_en,
    output logic [2:0] baud_select,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_param_check
        $error("uart_tx_arbiter: DEPTH must be a power of 2 >= 2, ACK_TIMEOUT >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic              tx_en_q;
    logic [2:0]        baud_q, baud_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;

    logic              push0, push1, pop0, pop1;
    logic [BYTE_W-1:0] head0, head1;
    logic              full0, full1, empty0, empty1;
    logic              ready0, ready1;
    logic              pick;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign push0 = req0_valid && ready0 && !full0;
    assign push1 = req1_valid && ready1 && !full1;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (req0_data),
        .pop       (pop0),
        .head      (head0),
        .full      (full0),
        .empty     (empty0),
        .ready     (ready0)
    );

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (req1_data),
        .pop       (pop1),
        .head      (head1),
        .full      (full1),
        .empty     (empty1),
        .ready     (ready1)
    );

    // With both pending, serve the one not granted last; otherwise the only one pending.
    assign pick = (!empty0 && !empty1) ? ~last_q : empty0;

    // Next-state, pops and next output values for the grant/handshake FSM.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pop0      = 1'b0;
        pop1      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // A busy transmitter here is a frame we did not start; hold off.
                if (en && !tx_busy && (!empty0 || !empty1)) begin
                    grant_d   = pick;
                    tx_data_d = pick ? head1 : head0;
                    pop0      = !pick;
                    pop1      = pick;
                    state_d   = WRITE;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            WRITE: begin
                if (tx_busy) begin
                    state_d = BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // No ack: drop the byte and move the pointer past this requester.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_wr_d = (state_d == WRITE);
    // Baud is only sampled between bytes so a frame in flight never sees a change.
    assign baud_d  = (state_q == IDLE) ? baud_cfg : baud_q;

    // State and registered transmitter-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            tx_en_q   <= 1'b0;
            baud_q    <= 3'b000;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;  // requester 0 wins the first tie
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            tx_en_q   <= en;
            baud_q    <= baud_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Ack-timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req0_ready  = ready0;
    assign req1_ready  = ready1;
    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign tx_en       = tx_en_q;
    assign baud_select = baud_q;
    assign grant_id    = grant_q;

endmodule
